uart_tx_stage: RTL and testbench

UART_TX_STAGE -- requirements
Module: uart_tx_stage

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_stage.sv | 157 +++++++++++++++
 tb/tb_uart_tx_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit stage.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int FRAME_BITS_NOPAR = 10;
    localparam int FRAME_BITS_PAR   = 11;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: registered storage, wrapping pointers,
// occupancy count and full/empty flags. Head byte is visible combinationally.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_stage.sv
// UART transmitter: byte FIFO, baud counter, frame FSM and registered tx line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_stage
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          en,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state, state_n;
    logic [DIV_W-1:0]  baud_cnt, baud_cnt_n;
    logic [DIV_W-1:0]  div_lat, div_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [BIT_W-1:0]  nxt_bit;
    logic [DATA_W-1:0] data_lat, data_n;
    logic [DATA_W-1:0] head;
    logic              tx_n;
    logic              bit_end;
    logic              pop;
    logic              full;
    logic              empty;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    assign wr_ready = !full;
    assign busy     = (state != ST_IDLE) || !empty;
    assign bit_end  = (baud_cnt == div_lat);
    assign nxt_bit  = bit_cnt + BIT_W'(1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            div_lat  <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            div_lat  <= div_n;
            tx       <= tx_n;
            overflow <= overflow | (wr_valid & ~wr_ready);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        data_lat <= data_n;
    end

    // tx_n is the value the line takes for the next clock; transitions only at bit ends.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        div_n      = div_lat;
        data_n     = data_lat;
        tx_n       = tx;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (en && !empty) begin
                    pop        = 1'b1;
                    data_n     = head;
                    div_n      = baud_div;
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                    tx_n       = 1'b0;
                    state_n    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    tx_n       = data_lat[0];
                    state_n    = ST_DATA;
                end else begin
                    baud_cnt_n = baud_cnt + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
                        tx_n      = even_parity(data_lat);
                        state_n   = ST_PARITY;
`else
                        tx_n      = 1'b1;
                        state_n   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_n = nxt_bit;
                        tx_n      = data_lat[nxt_bit];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    tx_n       = 1'b1;
                    state_n    = ST_STOP;
                end else begin
                    baud_cnt_n = baud_cnt + DIV_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    tx_n       = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    baud_cnt_n = baud_cnt + DIV_W'(1);
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage: frame timing, FIFO full/wrap, push/pop,
// reset abort, enable gating and divisor latching (parity when UART_TX_PARITY_EN).
module tb_uart_tx_stage;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] baud_div;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        tx;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] rd;
    logic       rp;
    logic       rok;
    int         rgap;

    uart_tx_stage #(
        .FIFO_DEPTH (8),
        .DIV_W      (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .en         (en),
        .baud_div   (baud_div),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Waits for a start bit, then walks every clock of the frame checking that
    // each bit window is constant; leaves the caller on the first clock after stop.
    task automatic rx_frame(input int div, output logic [7:0] data, output logic par,
                            output logic ok, output int gap);
        logic [NB-1:0] bits;
        logic          glitch;
        int            waited;
        waited = 0;
        glitch = 1'b0;
        bits   = '0;
        while (tx !== 1'b0 && waited < 3000) begin
            tick();
            waited++;
        end
        gap = waited;
        if (waited >= 3000) begin
            data = 8'h00;
            par  = 1'b0;
            ok   = 1'b0;
            return;
        end
        for (int b = 0; b < NB; b++) begin
            bits[b] = tx;
            for (int c = 0; c <= div; c++) begin
                if (tx !== bits[b]) glitch = 1'b1;
                tick();
            end
        end
        data = bits[8:1];
        par  = bits[NB-2];
        ok   = !glitch && (bits[0] == 1'b0) && (bits[NB-1] == 1'b1) && (tx === 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        baud_div = 16'd3;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tick();
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Single byte 0x55 at 4 clocks per bit
        en = 1'b1;
        wr(8'h55);
        chk("single_tx_after1", tx, 1);
        chk("single_count_after1", fifo_count, 1);
        tick();
        chk("single_tx_after2", tx, 0);
        chk("single_count_after2", fifo_count, 0);
        chk("single_busy", busy, 1);
        rx_frame(3, rd, rp, rok, rgap);
        chk("single_frame", {rok, rd}, {1'b1, 8'h55});
        chk("single_end_busy", busy, 0);
`ifdef UART_TX_PARITY_EN
        chk("single_parity", rp, 0);
`endif

        // Burst of 12 with en low: 8 accepted, 4 dropped
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("burst_wr_ready", wr_ready, (i < 8) ? 1 : 0);
            wr(8'(i));
        end
        chk("burst_count", fifo_count, 8);
        chk("burst_full", wr_ready, 0);
        chk("burst_overflow", overflow, 1);
        en = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    rx_frame(3, rd, rp, rok, rgap);
                    chk("burst_frame", {rok, rd}, {1'b1, 8'((i < 8) ? i : i + 4)});
                    chk("burst_gap", rgap, 1);
                end
            end
            begin
                for (int v = 12; v < 16; v++) begin
                    int n;
                    n = 0;
                    while (!wr_ready && n < 3000) begin
                        tick();
                        n++;
                    end
                    chk("burst_space_wait", (n < 3000) ? 1 : 0, 1);
                    wr(8'(v));
                end
            end
        join
        chk("burst_end_busy", busy, 0);

        // Push on the same cycle as the IDLE pop
        en = 1'b0;
        wr(8'hA1);
        wr(8'hA2);
        wr(8'hA3);
        chk("pushpop_pre_count", fifo_count, 3);
        en = 1'b1;
        wr(8'hA4);
        chk("pushpop_count", fifo_count, 3);
        chk("pushpop_tx", tx, 0);
        for (int i = 0; i < 4; i++) begin
            rx_frame(3, rd, rp, rok, rgap);
            chk("pushpop_frame", {rok, rd}, {1'b1, 8'hA1 + 8'(i)});
        end

        // Reset during data bit 4 of 0xA5 with a second byte queued
        en = 1'b0;
        wr(8'hA5);
        wr(8'h11);
        en = 1'b1;
        tick();
        chk("abort_start", tx, 0);
        repeat (21) tick();
        chk("abort_bit4", tx, 0);
        chk("abort_pre_overflow", overflow, 1);
        chk("abort_pre_count", fifo_count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_tx", tx, 1);
        chk("abort_count", fifo_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_wr_ready", wr_ready, 1);
        repeat (5) tick();
        chk("abort_quiet", {tx, busy}, {1'b1, 1'b0});

        // Enable drop and divisor change during frame 1 of 2
        en       = 1'b0;
        baud_div = 16'd3;
        wr(8'h3C);
        wr(8'hC3);
        en = 1'b1;
        fork
            begin
                rx_frame(3, rd, rp, rok, rgap);
            end
            begin
                repeat (6) tick();
                baud_div = 16'd7;
                en       = 1'b0;
            end
        join
        chk("endrop_frame1", {rok, rd}, {1'b1, 8'h3C});
        repeat (20) tick();
        chk("endrop_hold_tx", tx, 1);
        chk("endrop_hold_count", fifo_count, 1);
        chk("endrop_hold_busy", busy, 1);
        en = 1'b1;
        rx_frame(7, rd, rp, rok, rgap);
        chk("endrop_frame2", {rok, rd}, {1'b1, 8'hC3});
        chk("endrop_gap", rgap, 1);
        chk("endrop_end_busy", busy, 0);

`ifdef UART_TX_PARITY_EN
        baud_div = 16'd3;
        wr(8'h07);
        rx_frame(3, rd, rp, rok, rgap);
        chk("parity_07_frame", {rok, rd}, {1'b1, 8'h07});
        chk("parity_07_bit", rp, 1);
        wr(8'h03);
        rx_frame(3, rd, rp, rok, rgap);
        chk("parity_03_frame", {rok, rd}, {1'b1, 8'h03});
        chk("parity_03_bit", rp, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
